// File: rtl/imem_fetch_port.sv
// ============================================================================
// Module  : imem_fetch_port
// Purpose : Instruction memory with a valid/ready fetch port, one-cycle
//           registered read, a single-entry back-pressure output stage, a flush
//           for redirects and a run-time program-load port.
// Options : IMEM_WR_BYPASS_EN - forward ld_data on a same-cycle, same-index
//           load/fetch collision (write-through). When undefined, the old
//           word is returned (read-before-write).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_port #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic [1:0]               resp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [31:0]              fetch_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI    = 2 + IDX_W;

  // Storage holds each word XOR NOP_WORD, so zero-initialised storage reads
  // back as NOP_WORD everywhere without needing an explicit memory reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  index;
  logic              misaligned;
  logic              out_of_range;
  logic              accept;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] fwd_word;

  assign index      = req_addr[2 +: IDX_W];
  assign misaligned = |req_addr[1:0];

  generate
    if (ADDR_W > HI) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:HI];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  // The output slot can take a new word when empty or being drained; a flush
  // blocks any accept in its cycle.
  assign req_ready = !flush && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  assign rd_word = mem[index] ^ NOP_WORD;

`ifdef IMEM_WR_BYPASS_EN
  assign fwd_word = (ld_en && (ld_addr == index)) ? ld_data : rd_word;
`else
  assign fwd_word = rd_word;
`endif

  // Program-load write port; independent of the fetch handshake, not reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data ^ NOP_WORD;
    end
  end

  // Output stage: load on accept, hold on stall, empty on flush or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_instr <= NOP_WORD;
      resp_addr  <= '0;
      resp_err   <= 2'b00;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_addr  <= req_addr;
      resp_err   <= {out_of_range, misaligned};
      resp_instr <= (misaligned || out_of_range) ? NOP_WORD : fwd_word;
    end else if (flush || resp_ready || !resp_valid) begin
      resp_valid <= 1'b0;
    end
  end

  // Count completed response handshakes; a flush cancels the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
    end else if (resp_valid && resp_ready && !flush) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
